seq_det_hit_counter: RTL and testbench

//  Downstream stage of the 101 sequence detector: consumes its 1-bit match pulse
//  (out -> det_in) and counts matches over fixed windows of WIN_LEN clock cycles.

---
 rtl/seq_det_hit_counter.sv | 66 ++++++
 tb/tb_seq_det_hit_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_det_hit_counter.sv
// seq_det_hit_counter: counts detector match pulses over fixed windows and hands each window's count out through a one-entry valid/ready result register
module seq_det_hit_counter #(
  parameter int WIN_LEN = 64,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             det_in,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_count,
  output logic             res_sat,
  output logic             res_drop,
  output logic             busy
);
  localparam int WW = $clog2(WIN_LEN);
  typedef enum logic {IDLE, COUNT} state_t;
  state_t           state, state_n;
  logic [WW-1:0]    win_cnt, win_n;
  logic [CNT_W-1:0] hit_cnt, hit_n, hit_inc, res_count_n;
  logic             sat, sat_n, sat_fin, drop_pend, drop_n;
  logic             res_valid_n, res_sat_n, res_drop_n;
  logic             at_max, step, close, load;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state     <= IDLE;
      win_cnt   <= '0;
      hit_cnt   <= '0;
      sat       <= 1'b0;
      drop_pend <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_sat   <= 1'b0;
      res_drop  <= 1'b0;
    end else begin
      state     <= state_n;
      win_cnt   <= win_n;
      hit_cnt   <= hit_n;
      sat       <= sat_n;
      drop_pend <= drop_n;
      res_valid <= res_valid_n;
      res_count <= res_count_n;
      res_sat   <= res_sat_n;
      res_drop  <= res_drop_n;
    end
  // The closing sample is folded in combinationally so the result covers all WIN_LEN samples.
  always_comb begin
    at_max      = &hit_cnt;
    hit_inc     = hit_cnt + CNT_W'(det_in & ~at_max);
    sat_fin     = sat | (det_in & at_max);
    step        = (state == COUNT) && en;
    close       = step && (win_cnt == WW'(WIN_LEN - 1));
    load        = close && (!res_valid || res_ready);
    state_n     = en ? COUNT : IDLE;
    win_n       = (step && !close) ? win_cnt + 1'b1 : '0;
    hit_n       = (step && !close) ? hit_inc : '0;
    sat_n       = step && !close && sat_fin;
    res_valid_n = load || (res_valid && !res_ready);
    res_count_n = load ? hit_inc : res_count;
    res_sat_n   = load ? sat_fin : res_sat;
    res_drop_n  = load ? drop_pend : res_drop;
    drop_n      = load ? 1'b0 : (close || drop_pend);
  end
  assign busy = (state == COUNT);
endmodule

// File: tb/tb_seq_det_hit_counter.sv
// tb_seq_det_hit_counter: scoreboard bench for the windowed hit counter with WIN_LEN=8, CNT_W=3
module tb_seq_det_hit_counter;
  localparam int WIN = 8;
  localparam int CW = 3;
  localparam int MAXC = 7;
  typedef struct {int c; int s; int d;} exp_t;
  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, det_in = 1'b0, res_ready = 1'b0;
  logic res_valid, res_sat, res_drop, busy;
  logic [CW-1:0] res_count;
  int n_vec = 0, n_bad = 0;
  exp_t sb[$];
  int dlv_c[$], dlv_s[$], dlv_d[$];
  bit m_run, m_valid, m_drop;
  int m_idx, m_hits, ref_cnt, sum;
  logic [2:0] hist;

  seq_det_hit_counter #(.WIN_LEN(WIN), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .det_in(det_in), .res_ready(res_ready),
    .res_valid(res_valid), .res_count(res_count), .res_sat(res_sat),
    .res_drop(res_drop), .busy(busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_valid = 0; m_drop = 0; m_idx = 0; m_hits = 0;
    sb.delete();
  endtask

  task automatic clear_log();
    dlv_c.delete(); dlv_s.delete(); dlv_d.delete();
  endtask

  task automatic cycle(input logic e, input logic d, input logic r);
    exp_t x;
    bit acc;
    @(negedge clk);
    en = e; det_in = d; res_ready = r;
    chk("valid", res_valid, m_valid);
    chk("busy", busy, m_run);
    if (res_valid && r) begin
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("count", res_count, x.c);
        chk("sat", res_sat, x.s);
        chk("drop", res_drop, x.d);
      end
      dlv_c.push_back(res_count); dlv_s.push_back(res_sat); dlv_d.push_back(res_drop);
    end
    acc = m_valid && r;
    if (m_run && e) begin
      m_hits += d;
      if (m_idx == WIN - 1) begin
        if (!m_valid || r) begin
          x.c = (m_hits > MAXC) ? MAXC : m_hits;
          x.s = (m_hits > MAXC);
          x.d = m_drop;
          sb.push_back(x);
          m_drop = 0; m_valid = 1;
        end else m_drop = 1;
        m_idx = 0; m_hits = 0;
      end else begin
        m_idx++;
        if (acc) m_valid = 0;
      end
    end else begin
      m_idx = 0; m_hits = 0;
      if (acc) m_valid = 0;
    end
    m_run = e;
    @(posedge clk);
  endtask

  task automatic window(input logic [7:0] p, input logic [7:0] r);
    for (int i = 0; i < 8; i++) cycle(1'b1, p[i], r[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en = 1'($urandom); det_in = 1'($urandom); res_ready = 1'($urandom);
      chk("rst_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", res_count, 0);
      chk("rst_flags", {res_sat, res_drop}, 0);
    end
    @(negedge clk);
    en = 0; det_in = 1; rstn = 1;
    idle(3);
    chk("post_rst_count", res_count, 0);

    clear_log();
    cycle(1, 0, 1);
    window(8'b0010_1010, 8'hFF);
    idle(2);
    chk("t2_n", dlv_c.size(), 1);
    if (dlv_c.size() == 1) begin
      chk("t2_count", dlv_c[0], 3); chk("t2_sat", dlv_s[0], 0); chk("t2_drop", dlv_d[0], 0);
    end

    clear_log();
    cycle(1, 0, 1);
    window(8'hFF, 8'hFF);
    idle(2);
    chk("t3_n", dlv_c.size(), 1);
    if (dlv_c.size() == 1) begin
      chk("t3_count", dlv_c[0], 7); chk("t3_sat", dlv_s[0], 1);
    end

    clear_log();
    cycle(1, 0, 0);
    window(8'h01, 8'h00);
    window(8'h03, 8'h00);
    window(8'h07, 8'h00);
    window(8'h0F, 8'hFF);
    idle(2);
    chk("t4_n", dlv_c.size(), 2);
    if (dlv_c.size() == 2) begin
      chk("t4_c0", dlv_c[0], 1); chk("t4_d0", dlv_d[0], 0);
      chk("t4_c1", dlv_c[1], 4); chk("t4_d1", dlv_d[1], 1);
    end

    clear_log();
    cycle(1, 0, 1);
    repeat (4) cycle(1, 1, 1);
    cycle(0, 1, 1);
    cycle(0, 0, 1);
    chk("t5_busy", busy, 0);
    chk("t5_valid", res_valid, 0);
    cycle(1, 0, 1);
    window(8'h81, 8'hFF);
    idle(2);
    chk("t5_n", dlv_c.size(), 1);
    if (dlv_c.size() == 1) chk("t5_count", dlv_c[0], 2);

    clear_log();
    cycle(1, 0, 1);
    window(8'h03, 8'h00);
    window(8'h07, 8'h80);
    #1;
    chk("t6_valid", res_valid, 1);
    chk("t6_count", res_count, 3);
    idle(2);
    chk("t6_n", dlv_c.size(), 2);
    if (dlv_c.size() == 2) begin
      chk("t6_c0", dlv_c[0], 2); chk("t6_c1", dlv_c[1], 3); chk("t6_d1", dlv_d[1], 0);
    end

    clear_log();
    hist = 3'b000; ref_cnt = 0; sum = 0;
    cycle(1, 0, 1);
    for (int i = 0; i < 400; i++) begin
      hist = {hist[1:0], 1'($urandom)};
      if (hist == 3'b101) ref_cnt++;
      cycle(1, hist == 3'b101, 1);
    end
    idle(2);
    foreach (dlv_c[i]) sum += dlv_c[i];
    chk("sys_windows", dlv_c.size(), 50);
    chk("sys_sum", sum, ref_cnt);

    cycle(1, 0, 1);
    window(8'h01, 8'h00);
    cycle(1, 1, 0);
    #3 rstn = 0;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", res_count, 0);
    model_reset();
    @(negedge clk);
    en = 0; rstn = 1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
